// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_ctrl
// Description : Programmable serial sequence-detector controller. Holds a
//               pattern/length/overlap/target configuration, arms on start,
//               shifts qualified bits into a history register, pulses match
//               on each detection, counts matches and stops at the target.
//               Optional bit-count timeout enabled by SEQ_CTRL_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_ctrl #(
  parameter int PAT_W        = 8,
  parameter int LEN_W        = 4,
  parameter int CNT_W        = 8,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [LEN_W-1:0] c_PAT_W = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] c_ONE_L = LEN_W'(1);
  localparam logic [PAT_W-1:0] c_ONES  = '1;

  // State and configuration
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic             r_overlap;
  logic [CNT_W-1:0] r_target;

  // Detection datapath
  logic [PAT_W-1:0] r_hist;
  logic [LEN_W-1:0] r_fill;
  logic [CNT_W-1:0] r_cnt;
  logic             r_match;

  logic [LEN_W-1:0] w_len_clamped;
  logic             w_restart;
  logic             w_accept;
  logic [PAT_W-1:0] w_hist_new;
  logic [LEN_W-1:0] w_fill_inc;
  logic [PAT_W-1:0] w_mask;
  logic             w_hit;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_tgt_hit;
  logic             w_to_hit;

  // Length is clamped once at load so the run logic never sees 0 or > PAT_W
  assign w_len_clamped = (cfg_len == '0)     ? c_ONE_L :
                         (cfg_len > c_PAT_W) ? c_PAT_W : cfg_len;

  // abort outranks start everywhere; start restarts from IDLE, RUN or DONE
  assign w_restart = start && !abort;

  // A bit is only processed in RUN when neither abort nor restart claims the cycle
  assign w_accept = (r_state == S_RUN) && bit_valid && !abort && !start;

  assign w_hist_new = {r_hist[PAT_W-2:0], bit_in};
  assign w_fill_inc = (r_fill == c_PAT_W) ? r_fill : r_fill + c_ONE_L;

  // Shifting by len == PAT_W yields zero, so the mask becomes all ones
  assign w_mask = ~(c_ONES << r_len);

  assign w_hit = w_accept && (w_fill_inc >= r_len) &&
                 ((w_hist_new & w_mask) == (r_pat & w_mask));

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_tgt_hit = w_hit && (r_target != '0) && (w_cnt_inc == r_target);

`ifdef SEQ_CTRL_TIMEOUT_EN
  localparam int c_TB_W = $clog2(TIMEOUT_BITS + 1);
  localparam logic [c_TB_W-1:0] c_TB_LIM = c_TB_W'(TIMEOUT_BITS);

  logic [c_TB_W-1:0] r_tbits;
  logic [c_TB_W-1:0] w_tbits_inc;
  logic              r_timeout;

  assign w_tbits_inc = r_tbits + c_TB_W'(1);

  // A match on the limiting bit takes precedence over the timeout
  assign w_to_hit = w_accept && !w_hit && (w_tbits_inc == c_TB_LIM);

  // Bits-since-last-match counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tbits   <= '0;
      r_timeout <= 1'b0;
    end else if (w_restart) begin
      r_tbits   <= '0;
      r_timeout <= 1'b0;
    end else if (w_accept) begin
      r_tbits <= w_hit ? '0 : w_tbits_inc;
      if (w_to_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeout = r_timeout;
`else
  assign w_to_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: abort > start > bit processing
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_restart) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (start) begin
          w_state_nxt = S_RUN;
        end else if (w_tgt_hit || w_to_hit) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Status outputs decode the registered state
  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  // Configuration registers, writable only while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pat     <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
      r_target  <= '0;
    end else if ((r_state == S_IDLE) && cfg_we) begin
      r_pat     <= cfg_pattern;
      r_len     <= w_len_clamped;
      r_overlap <= cfg_overlap;
      r_target  <= cfg_target;
    end
  end

  // History shift, fill tracking, match pulse and match counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_cnt   <= '0;
      r_match <= 1'b0;
    end else begin
      r_match <= w_hit;
      if (w_restart) begin
        r_hist <= '0;
        r_fill <= '0;
        r_cnt  <= '0;
      end else if (w_accept) begin
        r_hist <= w_hist_new;
        // Non-overlap mode needs len fresh bits before the next match
        r_fill <= (w_hit && !r_overlap) ? '0 : w_fill_inc;
        if (w_hit) begin
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end

  assign match     = r_match;
  assign match_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detect_ctrl
// Description : Directed self-checking bench for seq_detect_ctrl. Timeout
//               checks are active when SEQ_CTRL_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic [7:0] cfg_target = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       match;
  logic [7:0] match_cnt;
  logic       busy;
  logic       done;
  logic       timeout;

  int n_chk  = 0;
  int n_fail = 0;

  seq_detect_ctrl #(
    .PAT_W       (8),
    .LEN_W       (4),
    .CNT_W       (8),
    .TIMEOUT_BITS(8)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .cfg_target (cfg_target),
    .start      (start),
    .abort      (abort),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .match      (match),
    .match_cnt  (match_cnt),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  // Count one comparison and report a mismatch
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len,
                        input logic ovl, input logic [7:0] tgt);
    @(negedge clk);
    cfg_we = 1'b1; cfg_pattern = pat; cfg_len = len;
    cfg_overlap = ovl; cfg_target = tgt;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic ctl(input logic s, input logic a);
    @(negedge clk);
    start = s; abort = a;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic send(input logic b, input logic a);
    @(negedge clk);
    bit_valid = 1'b1; bit_in = b; abort = a;
    @(posedge clk); #1;
    bit_valid = 1'b0; abort = 1'b0;
  endtask

  // Feed n bits (first bit is the MSB of the n-bit field) and check match per bit
  task automatic run_stream(input string tag, input logic [15:0] bits,
                            input int n, input logic [15:0] exp_m);
    for (int i = 0; i < n; i++) begin
      send(bits[n-1-i], 1'b0);
      check($sformatf("%s_match_bit%0d", tag, i + 1), {31'd0, match}, {31'd0, exp_m[n-1-i]});
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_match", {31'd0, match}, 32'd0);
    check("rst_cnt", {24'd0, match_cnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Non-overlap: one match after bit 4
    do_cfg(8'b1001, 4'd4, 1'b0, 8'd0);
    ctl(1'b1, 1'b0);
    check("novl_busy", {31'd0, busy}, 32'd1);
    run_stream("novl", 16'b1001001, 7, 16'b0001000);
    check("novl_cnt", {24'd0, match_cnt}, 32'd1);
    ctl(1'b0, 1'b1);
    check("novl_abort_idle", {30'd0, done, busy}, 32'd0);
    check("novl_cnt_kept", {24'd0, match_cnt}, 32'd1);

    // Overlap: matches after bits 4 and 7
    do_cfg(8'b1001, 4'd4, 1'b1, 8'd0);
    ctl(1'b1, 1'b0);
    check("ovl_cnt_clr", {24'd0, match_cnt}, 32'd0);
    run_stream("ovl", 16'b1001001, 7, 16'b0001001);
    check("ovl_cnt", {24'd0, match_cnt}, 32'd2);
    ctl(1'b0, 1'b1);

    // Target stop: DONE after bit 7, later bits ignored
    do_cfg(8'b1001, 4'd4, 1'b1, 8'd2);
    ctl(1'b1, 1'b0);
    run_stream("tgt", 16'b1001001001, 10, 16'b0001001000);
    check("tgt_done", {31'd0, done}, 32'd1);
    check("tgt_busy", {31'd0, busy}, 32'd0);
    check("tgt_cnt", {24'd0, match_cnt}, 32'd2);

    // start and abort together in DONE -> IDLE
    ctl(1'b1, 1'b1);
    check("done_sa_idle", {30'd0, done, busy}, 32'd0);
    check("done_sa_cnt", {24'd0, match_cnt}, 32'd2);

    // Config lock: a write of 1111 during RUN must not take effect
    do_cfg(8'b1001, 4'd4, 1'b0, 8'd0);
    ctl(1'b1, 1'b0);
    do_cfg(8'b1111, 4'd4, 1'b0, 8'd0);
    run_stream("lock", 16'b10011111, 8, 16'b00010000);
    check("lock_cnt", {24'd0, match_cnt}, 32'd1);
    ctl(1'b0, 1'b1);

    // Abort on the matching bit: match discarded, IDLE, count 0
    ctl(1'b1, 1'b0);
    run_stream("abrt", 16'b100, 3, 16'b000);
    send(1'b1, 1'b1);
    check("abrt_match", {31'd0, match}, 32'd0);
    check("abrt_idle", {30'd0, done, busy}, 32'd0);
    check("abrt_cnt", {24'd0, match_cnt}, 32'd0);

    // Length 0 is clamped to 1
    do_cfg(8'h01, 4'd0, 1'b0, 8'd0);
    ctl(1'b1, 1'b0);
    run_stream("len0", 16'b101, 3, 16'b101);
    check("len0_cnt", {24'd0, match_cnt}, 32'd2);
    ctl(1'b0, 1'b1);

    // Length 15 is clamped to PAT_W = 8
    do_cfg(8'hA5, 4'd15, 1'b0, 8'd0);
    ctl(1'b1, 1'b0);
    run_stream("len15", 16'b10100101, 8, 16'b00000001);
    check("len15_cnt", {24'd0, match_cnt}, 32'd1);
    ctl(1'b0, 1'b1);

`ifdef SEQ_CTRL_TIMEOUT_EN
    // Timeout after 8 accepted bits with no match
    do_cfg(8'b1001, 4'd4, 1'b0, 8'd0);
    ctl(1'b1, 1'b0);
    run_stream("to", 16'b0000000, 7, 16'b0000000);
    check("to_busy7", {31'd0, busy}, 32'd1);
    check("to_flag7", {31'd0, timeout}, 32'd0);
    send(1'b0, 1'b0);
    check("to_done", {31'd0, done}, 32'd1);
    check("to_flag", {31'd0, timeout}, 32'd1);
    check("to_cnt", {24'd0, match_cnt}, 32'd0);
    ctl(1'b1, 1'b0);
    check("to_clr", {31'd0, timeout}, 32'd0);
    check("to_rerun", {31'd0, busy}, 32'd1);
    ctl(1'b0, 1'b1);
`else
    // Without the timeout feature a long zero run never ends the run
    do_cfg(8'b1001, 4'd4, 1'b0, 8'd0);
    ctl(1'b1, 1'b0);
    for (int i = 0; i < 70; i++) send(1'b0, 1'b0);
    check("noto_busy", {31'd0, busy}, 32'd1);
    check("noto_flag", {31'd0, timeout}, 32'd0);
    ctl(1'b0, 1'b1);
`endif

    // Asynchronous reset mid-run while match is high
    do_cfg(8'b1001, 4'd4, 1'b0, 8'd0);
    ctl(1'b1, 1'b0);
    run_stream("arst", 16'b1001, 4, 16'b0001);
    rst = 1'b1;
    #1;
    check("arst_match", {31'd0, match}, 32'd0);
    check("arst_cnt", {24'd0, match_cnt}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Run-time controller for the serial sequence-detector datapath: configures the pattern, length and overlap mode, then arms, runs and stops detection on a qualified bit stream.
- Counts matches, stops at a programmed target count, and reports status to the host.
- Sits between the host/config logic and the serial input.
- Replaces hard-coded per-pattern Moore FSMs with one programmable block.

Parameters:
- PAT_W, 8, maximum pattern length in bits.
- LEN_W, 4, width of cfg_len; must hold PAT_W.
- CNT_W, 8, width of match counter and target.
- TIMEOUT_BITS, 64, number of accepted bits without a match before timeout; used only with SEQ_CTRL_TIMEOUT_EN.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- cfg_we  input  1  load configuration; honoured in IDLE only.
- cfg_pattern  input  PAT_W  pattern; bit [len-1] is the oldest bit, bit 0 is the newest.
- cfg_len  input  LEN_W  active pattern length.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_target  input  CNT_W  match count that ends a run; 0 = unlimited.
- start  input  1  arm detection.
- abort  input  1  stop detection and return to IDLE.
- bit_valid  input  1  bit_in is qualified this cycle.
- bit_in  input  1  serial data bit.
- match  output  1  one-cycle pulse per detected match.
- match_cnt  output  CNT_W  matches in the current or last run.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- timeout  output  1  run ended by timeout; tied 0 without the macro.

Behaviour:
- Reset: state=IDLE; history, fill, match_cnt, match, busy, done and timeout all 0; config registers (pattern, len, overlap, target) all 0.
- cfg_len clamping is applied at load: 0 stored as 1, values above PAT_W stored as PAT_W.
- States: IDLE, RUN, DONE. busy and done decode registered state.
- IDLE:
  - cfg_we loads the config registers.
  - start -> RUN; clears history, fill, match_cnt and timeout.
- RUN:
  - cfg_we is ignored.
  - On bit_valid: history <= {history[PAT_W-2:0], bit_in}; fill increments, saturating at PAT_W.
  - Match condition, evaluated on the updated history: (fill_new >= len) and (history_new[len-1:0] == pattern[len-1:0]).
  - On match: match pulses high in the cycle after the bit is accepted (registered, latency 1); match_cnt increments, wrapping at 2^CNT_W.
  - Non-overlap mode: fill is set to 0 after a match, so the next match needs len fresh bits. Overlap mode: fill is unchanged.
  - If target != 0 and the incremented count == target: next state DONE, entered in the same edge that raises match.
  - No bit_valid: no state change.
- DONE:
  - match_cnt is held; done=1.
  - start -> RUN, clearing as in IDLE.
  - abort -> IDLE.
- abort in RUN -> IDLE at the next edge; match_cnt retained; a match on that same bit is discarded.
- Priority: abort > start > match/bit processing. abort in IDLE has no effect.
- cfg_overlap, len, pattern and target are frozen for the whole run.
- rst asserted mid-run returns the block to the reset values immediately.

Optional Feature:
- Macro: SEQ_CTRL_TIMEOUT_EN.
- Defined:
  - A bit counter clears on start and on each match, and increments on each bit_valid in RUN.
  - When it reaches TIMEOUT_BITS with no match on that bit: next state DONE and timeout=1.
  - timeout stays high until the next start or rst.
- Undefined: no counter is built; timeout is constant 0; a run ends only by target or abort.

Test Plan:
- Non-overlap: pattern=1001, len=4, overlap=0, target=0; stream 1,0,0,1,0,0,1 -> exactly one match pulse, one cycle after bit 4; match_cnt=1.
- Overlap: same stream with overlap=1 -> match pulses after bit 4 and after bit 7; match_cnt=2.
- Target stop: overlap=1, target=2; stream 1,0,0,1,0,0,1,0,0,1 -> DONE after bit 7; bits 8-10 ignored; done=1, match_cnt=2.
- Config lock and priority:
  - cfg_we with pattern=1111 during RUN -> detection still uses 1001.
  - start and abort in the same cycle in DONE -> IDLE.
- Abort and reset: abort on the cycle bit 4 of 1001 is accepted -> no match pulse; IDLE; match_cnt=0. rst mid-run -> all outputs 0 asynchronously.
- Timeout (macro defined, TIMEOUT_BITS=8): start, then 8 zero bits -> DONE with timeout=1, match_cnt=0; a new start clears timeout.
